// File: rtl/johnson_phase_checker.sv
// Decodes a 4-bit Johnson counter into a phase index and tracks lock on a
// sequence of legal successor steps. Revolutions are counted while locked.
//
// state  | meaning
// SEARCH | no reference phase yet, waiting for any legal code
// ACQ    | counting consecutive legal steps toward lock
// LOCKED | sequence is valid; steps and holds keep lock
// FAULT  | lock lost; held until clr_err
module johnson_phase_checker #(
    parameter int unsigned LOCK_COUNT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] jc,
    input  logic       clr_err,
    output logic [2:0] phase,
    output logic [7:0] phase_oh,
    output logic       phase_vld,
    output logic       locked,
    output logic       wrap,
    output logic [7:0] revs,
    output logic       err_sticky
);

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] ACQ    = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;
    localparam logic [1:0] FAULT  = 2'd3;

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

    logic [1:0] state_q, state_d;
    logic [3:0] step_cnt_q, step_cnt_d;
    logic [2:0] phase_q, phase_d;
    logic [7:0] phase_oh_q, phase_oh_d;
    logic       phase_vld_q;
    logic       locked_q;
    logic       wrap_q, wrap_d;
    logic [7:0] revs_q, revs_d;
    logic       err_q, err_d;

    logic       legal;
    logic [2:0] idx;
    logic [2:0] phase_inc;
    logic [3:0] cnt_inc;
    logic       is_step, is_hold, is_bad;

    always_comb begin
        legal = 1'b1;
        idx   = 3'd0;
        case (jc)
            4'b0000: idx = 3'd0;
            4'b0001: idx = 3'd1;
            4'b0011: idx = 3'd2;
            4'b0111: idx = 3'd3;
            4'b1111: idx = 3'd4;
            4'b1110: idx = 3'd5;
            4'b1100: idx = 3'd6;
            4'b1000: idx = 3'd7;
            default: legal = 1'b0;
        endcase
    end

    // Steps are judged against the last legal phase, which survives illegal codes.
    assign phase_inc = phase_q + 3'd1;
    assign cnt_inc   = step_cnt_q + 4'd1;
    assign is_step   = legal && (idx == phase_inc);
    assign is_hold   = legal && (idx == phase_q);
    assign is_bad    = legal && !is_step && !is_hold;

    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        err_d      = err_q;
        if (clr_err) begin
            err_d = 1'b0;
        end
        case (state_q)
            SEARCH: begin
                if (legal) begin
                    state_d    = ACQ;
                    step_cnt_d = 4'd0;
                end
            end
            ACQ: begin
                if (!legal) begin
                    state_d    = SEARCH;
                    step_cnt_d = 4'd0;
                end else if (is_step) begin
                    step_cnt_d = cnt_inc;
                    if (cnt_inc == LOCK_CNT) begin
                        state_d = LOCKED;
                    end
                end else if (is_bad) begin
                    step_cnt_d = 4'd0;
                end
            end
            LOCKED: begin
                // A fault on the same edge as clr_err must still flag.
                if (!legal || is_bad) begin
                    state_d    = FAULT;
                    step_cnt_d = 4'd0;
                    err_d      = 1'b1;
                end
            end
            default: begin
                if (clr_err) begin
                    state_d = SEARCH;
                end
            end
        endcase
    end

    always_comb begin
        phase_d    = legal ? idx : phase_q;
        phase_oh_d = legal ? (8'b1 << idx) : 8'd0;
        wrap_d     = (state_q == LOCKED) && is_step && (idx == 3'd0);
        revs_d     = wrap_d ? (revs_q + 8'd1) : revs_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SEARCH;
            step_cnt_q  <= 4'd0;
            phase_q     <= 3'd0;
            phase_oh_q  <= 8'd0;
            phase_vld_q <= 1'b0;
            locked_q    <= 1'b0;
            wrap_q      <= 1'b0;
            revs_q      <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_cnt_q  <= step_cnt_d;
            phase_q     <= phase_d;
            phase_oh_q  <= phase_oh_d;
            phase_vld_q <= legal;
            locked_q    <= (state_d == LOCKED);
            wrap_q      <= wrap_d;
            revs_q      <= revs_d;
            err_q       <= err_d;
        end
    end

    assign phase      = phase_q;
    assign phase_oh   = phase_oh_q;
    assign phase_vld  = phase_vld_q;
    assign locked     = locked_q;
    assign wrap       = wrap_q;
    assign revs       = revs_q;
    assign err_sticky = err_q;

endmodule

// File: tb/tb_johnson_phase_checker.sv
// Directed bench for johnson_phase_checker: lock, hold, fault/clear, ACQ
// restart, revolution counter rollover and asynchronous reset.
module tb_johnson_phase_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] jc = 4'b0000;
    logic       clr_err = 1'b0;
    logic [2:0] phase;
    logic [7:0] phase_oh;
    logic       phase_vld;
    logic       locked;
    logic       wrap;
    logic [7:0] revs;
    logic       err_sticky;

    int checks = 0;
    int errors = 0;

    johnson_phase_checker #(.LOCK_COUNT(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .jc         (jc),
        .clr_err    (clr_err),
        .phase      (phase),
        .phase_oh   (phase_oh),
        .phase_vld  (phase_vld),
        .locked     (locked),
        .wrap       (wrap),
        .revs       (revs),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    // Apply one code and sample 1 time unit after the edge that captures it.
    task automatic drive(input logic [3:0] code);
        jc = code;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        clr_err = 1'b0;
        jc      = 4'b0111;
        #1;
        checks++;
        if ({phase, phase_oh, phase_vld, locked, wrap, revs, err_sticky} !== 23'd0) begin
            errors++;
            $display("FAIL reset_immediate: got %h expected 0",
                     {phase, phase_oh, phase_vld, locked, wrap, revs, err_sticky});
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({phase, phase_oh, phase_vld, locked, wrap, revs, err_sticky} !== 23'd0) begin
            errors++;
            $display("FAIL reset_held: got %h expected 0",
                     {phase, phase_oh, phase_vld, locked, wrap, revs, err_sticky});
        end
        reset = 1'b0;
    endtask

    task automatic test_lock_sequence();
        logic [3:0] codes [9] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
        logic [2:0] exp_ph [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        logic       exp_lk [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic       exp_wr [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 9; i++) begin
            drive(codes[i]);
            checks++;
            if (phase !== exp_ph[i] || phase_vld !== 1'b1 || phase_oh !== (8'b1 << exp_ph[i])) begin
                errors++;
                $display("FAIL lock_seq_phase[%0d]: got ph=%0d vld=%b oh=%b expected ph=%0d vld=1",
                         i, phase, phase_vld, phase_oh, exp_ph[i]);
            end
            checks++;
            if (locked !== exp_lk[i] || wrap !== exp_wr[i]) begin
                errors++;
                $display("FAIL lock_seq_state[%0d]: got locked=%b wrap=%b expected locked=%b wrap=%b",
                         i, locked, wrap, exp_lk[i], exp_wr[i]);
            end
        end
        checks++;
        if (revs !== 8'd1) begin
            errors++;
            $display("FAIL lock_seq_revs: got %0d expected 1", revs);
        end
        drive(4'h1);
        checks++;
        if (wrap !== 1'b0 || revs !== 8'd1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL wrap_single_cycle: got wrap=%b revs=%0d locked=%b expected 0 1 1",
                     wrap, revs, locked);
        end
    endtask

    task automatic test_hold();
        drive(4'h3);
        drive(4'h7);
        for (int i = 0; i < 5; i++) begin
            drive(4'h7);
            checks++;
            if (locked !== 1'b1 || phase !== 3'd3 || err_sticky !== 1'b0 || wrap !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: got locked=%b ph=%0d err=%b wrap=%b expected 1 3 0 0",
                         i, locked, phase, err_sticky, wrap);
            end
        end
    endtask

    task automatic test_fault_clear();
        logic       exp_lk [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0] codes [4] = '{4'h1, 4'h3, 4'h7, 4'hF};
        drive(4'b0101);
        checks++;
        if (phase_vld !== 1'b0 || phase_oh !== 8'd0 || phase !== 3'd3 ||
            locked !== 1'b0 || err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL fault_entry: got vld=%b oh=%b ph=%0d locked=%b err=%b expected 0 0 3 0 1",
                     phase_vld, phase_oh, phase, locked, err_sticky);
        end
        drive(4'hF);
        checks++;
        if (phase !== 3'd4 || phase_vld !== 1'b1 || locked !== 1'b0 || err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL fault_stays: got ph=%0d vld=%b locked=%b err=%b expected 4 1 0 1",
                     phase, phase_vld, locked, err_sticky);
        end
        clr_err = 1'b1;
        drive(4'h0);
        clr_err = 1'b0;
        checks++;
        if (err_sticky !== 1'b0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL fault_clear: got err=%b locked=%b expected 0 0", err_sticky, locked);
        end
        // From SEARCH the first code only enters ACQ, so lock comes on the fourth.
        for (int i = 0; i < 4; i++) begin
            drive(codes[i]);
            checks++;
            if (locked !== exp_lk[i]) begin
                errors++;
                $display("FAIL relock_after_clear[%0d]: got locked=%b expected %b",
                         i, locked, exp_lk[i]);
            end
        end
    endtask

    task automatic test_clr_err_nonfault();
        clr_err = 1'b1;
        drive(4'hE);
        checks++;
        if (locked !== 1'b1 || err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL clr_in_locked: got locked=%b err=%b expected 1 0", locked, err_sticky);
        end
        drive(4'b0101);
        checks++;
        if (locked !== 1'b0 || err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL fault_beats_clr: got locked=%b err=%b expected 0 1", locked, err_sticky);
        end
        drive(4'h0);
        clr_err = 1'b0;
        checks++;
        if (err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL clr_after_race: got err=%b expected 0", err_sticky);
        end
    endtask

    task automatic test_acq_jump();
        logic [3:0] codes [7] = '{4'h0, 4'h1, 4'h7, 4'hF, 4'hF, 4'hE, 4'hC};
        logic [2:0] exp_ph [7] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd4, 3'd5, 3'd6};
        logic       exp_lk [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0] codes2 [7] = '{4'h0, 4'h1, 4'hA, 4'h3, 4'h7, 4'hF, 4'hE};
        logic       exp_lk2 [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(codes[i]);
            checks++;
            if (locked !== exp_lk[i] || phase !== exp_ph[i]) begin
                errors++;
                $display("FAIL acq_jump[%0d]: got locked=%b ph=%0d expected locked=%b ph=%0d",
                         i, locked, phase, exp_lk[i], exp_ph[i]);
            end
        end
        // An illegal code in ACQ returns to SEARCH rather than just clearing the count.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(codes2[i]);
            checks++;
            if (locked !== exp_lk2[i] || err_sticky !== 1'b0) begin
                errors++;
                $display("FAIL acq_illegal[%0d]: got locked=%b err=%b expected locked=%b err=0",
                         i, locked, err_sticky, exp_lk2[i]);
            end
            if (i == 2) begin
                checks++;
                if (phase_vld !== 1'b0 || phase !== 3'd1) begin
                    errors++;
                    $display("FAIL illegal_holds_phase: got vld=%b ph=%0d expected 0 1",
                             phase_vld, phase);
                end
            end
        end
    endtask

    task automatic test_revs_256();
        logic [3:0] rev [8] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h1, 4'h3, 4'h7};
        int wraps = 0;
        do_reset();
        drive(4'h0);
        drive(4'h1);
        drive(4'h3);
        drive(4'h7);
        for (int r = 0; r < 256; r++) begin
            for (int j = 0; j < 8; j++) begin
                drive(rev[j]);
                if (wrap === 1'b1) wraps++;
                if (r == 254 && j == 7) begin
                    checks++;
                    if (revs !== 8'd255) begin
                        errors++;
                        $display("FAIL revs_255: got %0d expected 255", revs);
                    end
                end
            end
        end
        checks++;
        if (wraps != 256) begin
            errors++;
            $display("FAIL wrap_pulses: got %0d expected 256", wraps);
        end
        checks++;
        if (revs !== 8'd0 || locked !== 1'b1 || err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL revs_rollover: got revs=%0d locked=%b err=%b expected 0 1 0",
                     revs, locked, err_sticky);
        end
    endtask

    task automatic test_reset_midop();
        logic [3:0] rev [8] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h1, 4'h3, 4'h7};
        do_reset();
        drive(4'h0);
        drive(4'h1);
        drive(4'h3);
        drive(4'h7);
        for (int r = 0; r < 5; r++)
            for (int j = 0; j < 8; j++) drive(rev[j]);
        checks++;
        if (revs !== 8'd5 || locked !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_state: got revs=%0d locked=%b expected 5 1", revs, locked);
        end
        clr_err = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({phase, phase_oh, phase_vld, locked, wrap, revs, err_sticky} !== 23'd0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0",
                     {phase, phase_oh, phase_vld, locked, wrap, revs, err_sticky});
        end
        @(posedge clk);
        #1;
        reset   = 1'b0;
        clr_err = 1'b0;
        drive(4'h1);
        checks++;
        if (locked !== 1'b0 || phase !== 3'd1 || revs !== 8'd0) begin
            errors++;
            $display("FAIL post_reset_first: got locked=%b ph=%0d revs=%0d expected 0 1 0",
                     locked, phase, revs);
        end
        drive(4'h3);
        drive(4'h7);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_early_lock: got locked=%b expected 0", locked);
        end
        drive(4'hF);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_relock: got locked=%b expected 1", locked);
        end
    endtask

    initial begin
        test_reset();
        test_lock_sequence();
        test_hold();
        test_fault_clear();
        test_clr_err_nonfault();
        test_acq_jump();
        test_revs_256();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
